// File: rtl/fpmul_seq_if.sv
// fpmul_seq_if: operand/result handshake bundle for the sequential FP multiplier.
// Request side: in_valid/in_ready with operands a, b and rounding mode rm.
// Response side: out_valid/out_ready with product out and flags {invalid, overflow, underflow, inexact}.
interface fpmul_seq_if #(
  parameter int EXP_BIT = 8,
  parameter int MAN_BIT = 23
);
  localparam int N_BIT = 1 + EXP_BIT + MAN_BIT;

  logic             in_valid;
  logic             in_ready;
  logic [N_BIT-1:0] a;
  logic [N_BIT-1:0] b;
  logic [1:0]       rm;
  logic             out_valid;
  logic             out_ready;
  logic [N_BIT-1:0] out;
  logic [3:0]       flags;

  // Issuer side: presents operands, consumes results.
  modport master (
    output in_valid, a, b, rm, out_ready,
    input  in_ready, out_valid, out, flags
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, rm, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fpmul_seq.sv
// fpmul_seq: IEEE-style FP multiplier, radix-2 shift-add significand product, 4 rounding modes, IEEE flags.
// Latency: out_valid rises MAN_BIT+3 cycles after the accepting edge, independent of operand class.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, rst (sync active-high), io (fpmul_seq_if.slave: in_valid/in_ready/a/b/rm, out_valid/out_ready/out/flags).
module fpmul_seq #(
  parameter int EXP_BIT = 8,
  parameter int MAN_BIT = 23
) (
  input  logic        clk,
  input  logic        rst,
  fpmul_seq_if.slave  io
);
  localparam int N_BIT = 1 + EXP_BIT + MAN_BIT;
  localparam int SW    = MAN_BIT + 1;          // significand width incl. hidden bit
  localparam int PW    = 2 * SW;               // product width
  localparam int CW    = $clog2(SW + 1);
  localparam int BIAS  = (1 << (EXP_BIT - 1)) - 1;
  localparam int EMAX  = (1 << EXP_BIT) - 1;
  localparam int SUMW  = EXP_BIT + MAN_BIT + 1;

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]       cnt_q;
  logic [PW-1:0]       mcand_q, acc_q;
  logic [SW-1:0]       mplier_q;
  logic                sign_q, qnan_q, invalid_q, inf_q, zero_q;
  logic [1:0]          rm_q;
  logic signed [31:0]  eexp_q, nexp_q;
  logic [MAN_BIT-1:0]  nman_q;
  logic                g_q, r_q, s_q, tiny_q;

  // ---------------- operand classification (on the live inputs, latched on accept)
  logic [EXP_BIT-1:0] ea, eb;
  logic [MAN_BIT-1:0] ma, mb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic signed [31:0] eexp_in;

  always_comb begin
    ea      = io.a[N_BIT-2 -: EXP_BIT];
    eb      = io.b[N_BIT-2 -: EXP_BIT];
    ma      = io.a[MAN_BIT-1:0];
    mb      = io.b[MAN_BIT-1:0];
    a_nan   = (&ea) & (|ma);
    b_nan   = (&eb) & (|mb);
    a_snan  = a_nan & ~ma[MAN_BIT-1];
    b_snan  = b_nan & ~mb[MAN_BIT-1];
    a_inf   = (&ea) & ~(|ma);
    b_inf   = (&eb) & ~(|mb);
    a_zero  = ~(|ea) & ~(|ma);
    b_zero  = ~(|eb) & ~(|mb);
    // Denormals use exponent 1 with hidden bit 0.
    eexp_in = $signed(32'(ea) + 32'(ea == '0) + 32'(eb) + 32'(eb == '0) - 32'(BIAS));
  end

  // ---------------- normalisation of the raw product
  logic [31:0]        lead, sh;
  logic signed [31:0] e_n, sh_raw, e_c;
  logic [PW-1:0]      pn, shifted;
  logic               lost, tiny;

  always_comb begin
    lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (acc_q[i]) lead = 32'(i);
    end
    // Binary point of the product sits below bit 2*MAN_BIT.
    e_n    = eexp_q + $signed(lead) - $signed(32'(2 * MAN_BIT));
    pn     = acc_q << (32'(PW - 1) - lead);
    tiny   = (e_n < 1);
    sh_raw = 32'sd1 - e_n;
    sh     = '0;
    if (tiny) sh = (sh_raw > $signed(32'(PW))) ? 32'(PW) : 32'(sh_raw);
    shifted = pn >> sh;
    lost    = |(pn & ~({PW{1'b1}} << sh));
    // A tiny result's exponent field is its (post-shift) hidden bit, i.e. 0.
    e_c     = tiny ? $signed(32'(shifted[PW-1])) : e_n;
  end

  // ---------------- rounding and result assembly
  logic            pre_ovf, inc, ovf, grs, inexact, to_inf;
  logic [SUMW-1:0] sum;
  logic [N_BIT-1:0] res;
  logic [3:0]      flg;

  always_comb begin
    grs     = g_q | r_q | s_q;
    unique case (rm_q)
      2'd0:    inc = g_q & (r_q | s_q | nman_q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = sign_q & grs;
      default: inc = ~sign_q & grs;
    endcase
    pre_ovf = (nexp_q >= $signed(32'(EMAX)));
    // Mantissa carry-out ripples straight into the exponent field.
    sum     = {1'b0, nexp_q[EXP_BIT-1:0], nman_q} + SUMW'(inc);
    ovf     = pre_ovf | (sum[SUMW-1 -: EXP_BIT+1] >= (EXP_BIT+1)'(EMAX));
    inexact = grs | ovf;
    to_inf  = (rm_q == 2'd0) | ((rm_q == 2'd3) & ~sign_q) | ((rm_q == 2'd2) & sign_q);
    res     = {sign_q, sum[SUMW-2:0]};
    flg     = {1'b0, ovf, tiny_q & inexact, inexact};
    if (ovf) begin
      res = to_inf ? {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}}
                   : {sign_q, EXP_BIT'(EMAX - 1), {MAN_BIT{1'b1}}};
    end
    if (qnan_q) begin
      res = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
      flg = {invalid_q, 3'b000};
    end else if (inf_q) begin
      res = {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
      flg = '0;
    end else if (zero_q) begin
      res = {sign_q, {(N_BIT-1){1'b0}}};
      flg = '0;
    end
  end

  // ---------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_d = MUL;
      end
      MUL:   if (cnt_q == CW'(MAN_BIT)) state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = DONE;
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0; mcand_q <= '0; mplier_q <= '0; acc_q <= '0;
      sign_q <= 1'b0; qnan_q <= 1'b0; invalid_q <= 1'b0; inf_q <= 1'b0; zero_q <= 1'b0;
      rm_q <= '0; eexp_q <= '0; nexp_q <= '0; nman_q <= '0;
      g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0; tiny_q <= 1'b0;
      io.out <= '0; io.flags <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (io.in_valid) begin
          mcand_q   <= PW'({|ea, ma});
          mplier_q  <= {|eb, mb};
          acc_q     <= '0;
          cnt_q     <= '0;
          rm_q      <= io.rm;
          sign_q    <= io.a[N_BIT-1] ^ io.b[N_BIT-1];
          eexp_q    <= eexp_in;
          qnan_q    <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
          invalid_q <= a_snan | b_snan | (a_inf & b_zero) | (b_inf & a_zero);
          inf_q     <= a_inf | b_inf;
          zero_q    <= a_zero | b_zero;
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        NORM: begin
          nexp_q <= e_c;
          nman_q <= shifted[PW-2 -: MAN_BIT];
          g_q    <= shifted[PW-2-MAN_BIT];
          r_q    <= shifted[PW-3-MAN_BIT];
          s_q    <= (|shifted[PW-4-MAN_BIT:0]) | lost;
          tiny_q <= tiny;
        end
        ROUND: begin
          io.out   <= res;
          io.flags <= flg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpmul_seq.sv
// tb_fpmul_seq: directed vector table plus backpressure and mid-operation reset sequences for fpmul_seq.
module tb_fpmul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpmul_seq_if #(.EXP_BIT(8), .MAN_BIT(23)) bus ();
  fpmul_seq #(.EXP_BIT(8), .MAN_BIT(23)) dut (.clk(clk), .rst(rst), .io(bus));

  localparam int LAT = 26;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present an op, wait for its acceptance and for out_valid; leaves the result pending.
  task automatic issue_wait(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                            output int lat);
    int w;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.rm = rm; bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;

  // flags: 8=invalid 4=overflow 2=underflow 1=inexact
  vec_t vecs [15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] r;
    logic [3:0]  f;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'h0};
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'h1};
    vecs[2]  = '{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800003, 4'h1};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'h1};
    vecs[4]  = '{32'hBF800001, 32'h3F800001, 2'd2, 32'hBF800003, 4'h1};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 2'd0, 32'h7F800000, 4'h5};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 2'd1, 32'h7F7FFFFF, 4'h5};
    vecs[7]  = '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'h8};
    vecs[8]  = '{32'h7FA00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h8};
    vecs[9]  = '{32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'h0};
    vecs[10] = '{32'h00800001, 32'h3F000000, 2'd0, 32'h00400000, 4'h3};
    vecs[11] = '{32'h00800001, 32'h3F000000, 2'd3, 32'h00400001, 4'h3};
    vecs[12] = '{32'h80000000, 32'h40000000, 2'd0, 32'h80000000, 4'h0};
    vecs[13] = '{32'h7F800000, 32'hBF800000, 2'd0, 32'hFF800000, 4'h0};
    vecs[14] = '{32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'h0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.rm = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out",       bus.out,            32'h0);
    check("rst flags",     32'(bus.flags),     32'h0);
    @(negedge clk) rst = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      issue_wait(vecs[i].a, vecs[i].b, vecs[i].rm, lat);
      check($sformatf("vec%0d latency", i), 32'(lat),       32'(LAT));
      check($sformatf("vec%0d out", i),     bus.out,        vecs[i].exp_out);
      check($sformatf("vec%0d flags", i),   32'(bus.flags), 32'(vecs[i].exp_flags));
      handshake();
    end

    // Backpressure: result held while out_ready low, competing request ignored
    issue_wait(32'h3F800001, 32'h3F800001, 2'd3, lat);
    check("bp op1 latency", 32'(lat), 32'(LAT));
    @(negedge clk);
    bus.a = 32'h40000000; bus.b = 32'h40400000; bus.rm = 2'd0; bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d out", c),       bus.out,             32'h3F800003);
      check($sformatf("bp hold%0d flags", c),     32'(bus.flags),      32'h1);
      check($sformatf("bp hold%0d in_ready", c),  32'(bus.in_ready),   32'd0);
      check($sformatf("bp hold%0d out_valid", c), 32'(bus.out_valid),  32'd1);
    end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("bp release in_ready",  32'(bus.in_ready),  32'd1);
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
    check("bp op2 latency", 32'(lat),       32'(LAT));
    check("bp op2 out",     bus.out,        32'h40C00000);
    check("bp op2 flags",   32'(bus.flags), 32'h0);
    handshake();

    // Reset in the middle of MUL
    @(negedge clk);
    bus.a = 32'h7F000000; bus.b = 32'h7F000000; bus.rm = 2'd0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out",       bus.out,            32'h0);
    check("midrst flags",     32'(bus.flags),     32'h0);
    @(negedge clk) rst = 1'b0;
    issue_wait(32'h3F800001, 32'h3F800001, 2'd1, lat);
    r = bus.out;
    f = bus.flags;
    check("post-rst latency", 32'(lat), 32'(LAT));
    check("post-rst out",     r,        32'h3F800002);
    check("post-rst flags",   32'(f),   32'h1);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
